cfg_reg_bank: RTL and testbench
===============================

# cfg_reg_bank

Parametrised, double-buffered register bank that generalises the single 16-bit load register into NUM_REGS channels of WIDTH bits. Each channel has a shadow copy that supports byte-masked load, increment and clear operations. Shadow contents reach the active copy only on an atomic commit. It sits between the command/config path and the DDR3 controller datapath, which consumes the flattened active values directly and through a registered read port.

## Interface

Parameters:
- WIDTH, 16, register width in bits; must be a multiple of 8
- NUM_REGS, 4, number of register channels; must be at least 1
- ADDR_W, 2, address width; must satisfy 2^ADDR_W >= NUM_REGS
- RESET_VAL, 0, WIDTH-bit value loaded into every shadow and active register on reset and by the clear op

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous and active-low
- load  in  1  write strobe for the shadow register selected by addr
- op  in  2  write operation: 00 load, 01 increment, 10 clear, 11 hold
- addr  in  ADDR_W  write target channel
- dataIn  in  WIDTH  write data for op=00
- be  in  WIDTH/8  byte enables for op=00; bit i gates dataIn[8i+7:8i]
- commit  in  1  copies all shadow registers into the active registers
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read channel
- rd_data  out  WIDTH  registered active value of rd_addr
- rd_valid  out  1  high for one cycle when rd_data holds a response
- dataOut  out  NUM_REGS*WIDTH  active registers flattened; channel k at [k*WIDTH +: WIDTH]
- pending  out  1  high while any shadow write is not yet committed

## Operation

- Reset (rst_n=0 at an edge) has priority over all other inputs. Every shadow and active register takes RESET_VAL. rd_data=0, rd_valid=0, pending=0. Any read in flight is dropped.
- Write (load=1, addr<NUM_REGS) updates only the shadow register of the addressed channel:
  - op=00: for each byte, shadow byte <= dataIn byte if be bit=1, else unchanged. be=0 leaves the value unchanged.
  - op=01: shadow <= shadow+1 modulo 2^WIDTH; all-ones wraps to 0; be ignored.
  - op=10: shadow <= RESET_VAL; be ignored.
  - op=11: no change.
- A write with addr>=NUM_REGS is silently ignored.
- pending is set by any accepted write with op!=11, including a load with be=0.
- commit=1: every active register <= current shadow value, all channels in the same edge. pending clears unless a write is accepted in the same cycle.
- Simultaneous commit and write:
  - commit copies the shadow value from before the write.
  - The write lands in shadow.
  - pending=1 afterwards.
- Read:
  - rd_en=1 captures active[rd_addr] into rd_data and sets rd_valid=1 at the next edge.
  - rd_en=0 gives rd_valid=0; rd_data holds its last value.
  - rd_addr>=NUM_REGS returns rd_data=0 with rd_valid=1.
- A read coincident with commit returns the pre-commit active value.
- Back-to-back reads are accepted every cycle. There is no backpressure.

## Timing

- Write to shadow: 1 edge. Shadow is not externally visible.
- Write to dataOut: the write edge, then a commit on a later edge. The minimum is 2 edges: write at cycle N, commit at cycle N+1, dataOut valid after edge N+1.
- Commit to dataOut: 1 edge. All channels change together, with no cycle showing a partial update.
- Read latency: exactly 1 cycle from rd_en to rd_valid/rd_data.
- pending timing:
  - Rises after the edge that accepts a write.
  - Falls after the edge of a commit with no coincident write.
- Reset mid-operation:
  - The edge with rst_n=0 discards uncommitted shadow writes.
  - That edge overrides a coincident commit or read.
  - Outputs return to reset values after that edge.
- Combinational paths: none from inputs to outputs. All outputs are registered.

## Test plan

- Reset with defaults: hold rst_n=0 for 2 edges, then release -> dataOut=0, rd_valid=0, pending=0. Read of each channel returns 0x0000 one cycle after rd_en.
- Write then commit:
  - Stimulus: load ch1 op=00 dataIn=0x00FE be=11, with no commit for 3 cycles.
  - Response during the wait: dataOut ch1 stays 0x0000 and pending=1.
  - Stimulus: commit=1.
  - Response: ch1=0x00FE, pending=0.
- Byte enables and out-of-range:
  - Stimulus: ch0=0x1234 committed, then load ch0 dataIn=0x0FE6 be=01, then commit.
  - Response: ch0=0x12E6.
  - Stimulus: load with addr=NUM_REGS (when 2^ADDR_W>NUM_REGS), then commit.
  - Response: no channel changes and pending stays 0.
- Increment wrap and clear:
  - Stimulus: ch2=0xFFFF, then op=01, then commit.
  - Response: 0x0000.
  - Stimulus: op=01 twice, then commit.
  - Response: 0x0002.
  - Stimulus: op=10, then commit.
  - Response: RESET_VAL.
- Simultaneous events:
  - Stimulus: shadow ch3=0xAAAA uncommitted; assert commit together with load ch3=0x5555 be=11.
  - Response: dataOut ch3=0xAAAA and pending=1.
  - Stimulus: a read of ch3 in that same cycle.
  - Response: returns the old active value.
  - Stimulus: next commit.
  - Response: ch3=0x5555.
- Reset mid-operation:
  - Stimulus: uncommitted writes on all channels, then rst_n=0 in the same cycle as commit and rd_en.
  - Response: dataOut all RESET_VAL, rd_valid=0 next cycle, pending=0.

Source files
------------

// File: rtl/cfg_reg_bank.sv
// cfg_reg_bank: double-buffered bank of NUM_REGS configuration registers.
// Writes (byte-masked load, increment, clear) land in a shadow copy. A commit
// copies every shadow register into the active copy on one edge, so the
// datapath never sees a partially updated set. Active values are exported
// flattened and through a one-cycle registered read port.
module cfg_reg_bank #(
    parameter int              WIDTH     = 16,
    parameter int              NUM_REGS  = 4,
    parameter int              ADDR_W    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [1:0]                op,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [WIDTH-1:0]          dataIn,
    input  logic [WIDTH/8-1:0]        be,
    input  logic                      commit,
    input  logic                      rd_en,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_valid,
    output logic [NUM_REGS*WIDTH-1:0] dataOut,
    output logic                      pending
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] shadow [NUM_REGS];
    logic [WIDTH-1:0] active [NUM_REGS];

    logic             wr_hit;
    logic             wr_change;
    logic [WIDTH-1:0] rd_sel;

    // New shadow value for one channel given the requested operation.
    function automatic logic [WIDTH-1:0] next_shadow(
        input logic [WIDTH-1:0] cur,
        input logic [1:0]       o,
        input logic [WIDTH-1:0] d,
        input logic [NB-1:0]    m
    );
        logic [WIDTH-1:0] r;
        r = cur;
        case (o)
            2'b00: begin
                for (int i = 0; i < NB; i++) begin
                    if (m[i]) r[8*i +: 8] = d[8*i +: 8];
                end
            end
            2'b01:   r = cur + WIDTH'(1);
            2'b10:   r = RESET_VAL;
            default: r = cur;
        endcase
        return r;
    endfunction

    // Address decode: write acceptance and read mux (out-of-range reads give 0).
    always_comb begin
        wr_hit = 1'b0;
        rd_sel = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (addr == ADDR_W'(k))    wr_hit = load;
            if (rd_addr == ADDR_W'(k)) rd_sel = active[k];
        end
        wr_change = wr_hit && (op != 2'b11);
    end

    // Shadow writes; a coincident commit still sees the pre-write shadow.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_REGS; k++) begin
            if (!rst_n) begin
                shadow[k] <= RESET_VAL;
            end else if (load && addr == ADDR_W'(k)) begin
                shadow[k] <= next_shadow(shadow[k], op, dataIn, be);
            end
        end
    end

    // Atomic commit of every channel into the active copy.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_REGS; k++) begin
            if (!rst_n) begin
                active[k] <= RESET_VAL;
            end else if (commit) begin
                active[k] <= shadow[k];
            end
        end
    end

    // Registered read port; reads coincident with commit return pre-commit data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_sel;
        end
    end

    // Pending flag: any effective write sets it, a commit without one clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (wr_change) begin
            pending <= 1'b1;
        end else if (commit) begin
            pending <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign dataOut[k*WIDTH +: WIDTH] = active[k];
    end

endmodule

// File: tb/tb_cfg_reg_bank.sv
// Testbench for cfg_reg_bank: directed stimulus, an array-based reference
// model updated once per cycle, a per-cycle compare process and literal checks.
module tb_cfg_reg_bank;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int AW = 3;   // wider than needed so out-of-range addresses exist

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [W-1:0]  dataIn;
    logic [1:0]    be;
    logic          commit;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic [N*W-1:0] dataOut;
    logic          pending;

    cfg_reg_bank #(.WIDTH(W), .NUM_REGS(N), .ADDR_W(AW), .RESET_VAL(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .op(op), .addr(addr),
        .dataIn(dataIn), .be(be), .commit(commit), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .dataOut(dataOut), .pending(pending)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model state
    int m_shadow [N];
    int m_active [N];
    int m_pending;
    int m_rd_data;
    int m_rd_valid;
    bit chk_en = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int chan(input int k);
        return int'(dataOut[k*W +: W]);
    endfunction

    // Model: apply the documented rules for one clock edge.
    task automatic model_edge(input bit rn, input bit l, input int o, input int a,
                              input int d, input int b, input bit c, input bit re,
                              input int ra);
        int old_shadow [N];
        if (!rn) begin
            for (int k = 0; k < N; k++) begin
                m_shadow[k] = 0;
                m_active[k] = 0;
            end
            m_pending = 0; m_rd_data = 0; m_rd_valid = 0;
            return;
        end
        for (int k = 0; k < N; k++) old_shadow[k] = m_shadow[k];
        // read sees active before the commit
        if (re) begin
            m_rd_valid = 1;
            m_rd_data  = (ra < N) ? m_active[ra] : 0;
        end else begin
            m_rd_valid = 0;
        end
        // commit sees shadow before the write
        if (c) for (int k = 0; k < N; k++) m_active[k] = old_shadow[k];
        if (l && a < N) begin
            case (o)
                0: begin
                    int lo, hi;
                    lo = (b % 2 == 1) ? (d % 256) : (m_shadow[a] % 256);
                    hi = (b >= 2) ? (d / 256) : (m_shadow[a] / 256);
                    m_shadow[a] = hi * 256 + lo;
                end
                1: m_shadow[a] = (m_shadow[a] + 1) % 65536;
                2: m_shadow[a] = 0;
                default: ;
            endcase
        end
        if (l && a < N && o != 3) m_pending = 1;
        else if (c)               m_pending = 0;
    endtask

    // One clock: drive inputs, update the model, wait past the falling edge.
    task automatic cyc(input bit rn, input bit l, input int o, input int a,
                       input int d, input int b, input bit c, input bit re,
                       input int ra);
        rst_n   = rn;
        load    = l;
        op      = 2'(o);
        addr    = AW'(a);
        dataIn  = W'(d);
        be      = 2'(b);
        commit  = c;
        rd_en   = re;
        rd_addr = AW'(ra);
        model_edge(rn, l, o, a, d, b, c, re, ra);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 3, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int a, input int o, input int d, input int b);
        cyc(1, 1, o, a, d, b, 0, 0, 0);
    endtask

    task automatic do_commit();
        cyc(1, 0, 3, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic rd(input int ra);
        cyc(1, 0, 3, 0, 0, 0, 0, 1, ra);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < N; k++) check($sformatf("dataOut_ch%0d", k), chan(k), m_active[k]);
            check("pending", int'(pending), m_pending);
            check("rd_valid", int'(rd_valid), m_rd_valid);
            check("rd_data", int'(rd_data), m_rd_data);
        end
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            m_shadow[k] = 0;
            m_active[k] = 0;
        end
        m_pending = 0; m_rd_data = 0; m_rd_valid = 0;

        // Reset held for two edges
        cyc(0, 0, 3, 0, 0, 0, 0, 0, 0);
        chk_en = 1;
        cyc(0, 0, 3, 0, 0, 0, 0, 0, 0);
        check("lit_reset_dataOut", int'(dataOut == '0), 1);
        check("lit_reset_pending", int'(pending), 0);
        check("lit_reset_rd_valid", int'(rd_valid), 0);
        for (int k = 0; k < N; k++) begin
            rd(k);
            check($sformatf("lit_reset_read_ch%0d", k), int'(rd_data), 16'h0000);
            check("lit_reset_read_valid", int'(rd_valid), 1);
        end

        // Write then commit after a wait
        wr(1, 0, 16'h00FE, 3);
        idle(3);
        check("lit_wait_ch1", chan(1), 16'h0000);
        check("lit_wait_pending", int'(pending), 1);
        do_commit();
        check("lit_commit_ch1", chan(1), 16'h00FE);
        check("lit_commit_pending", int'(pending), 0);

        // Read hold and out-of-range read
        rd(1);
        check("lit_read_ch1", int'(rd_data), 16'h00FE);
        idle(1);
        check("lit_read_hold", int'(rd_data), 16'h00FE);
        check("lit_read_idle_valid", int'(rd_valid), 0);
        rd(5);
        check("lit_read_oor", int'(rd_data), 0);
        check("lit_read_oor_valid", int'(rd_valid), 1);

        // Byte enables
        wr(0, 0, 16'h1234, 3);
        do_commit();
        wr(0, 0, 16'h0FE6, 1);
        do_commit();
        check("lit_be_ch0", chan(0), 16'h12E6);
        wr(0, 0, 16'hAB00, 2);
        do_commit();
        check("lit_be_hi_ch0", chan(0), 16'hABE6);

        // Out-of-range write is ignored
        wr(4, 0, 16'hFFFF, 3);
        check("lit_oor_pending", int'(pending), 0);
        do_commit();
        check("lit_oor_flat", int'(dataOut == 64'h0000_0000_00FE_ABE6), 1);

        // be=0 load still marks pending
        wr(2, 0, 16'h5A5A, 0);
        check("lit_be0_pending", int'(pending), 1);
        do_commit();
        check("lit_be0_ch2", chan(2), 0);

        // Increment wrap and clear
        wr(2, 0, 16'hFFFF, 3);
        wr(2, 1, 0, 0);
        do_commit();
        check("lit_wrap_ch2", chan(2), 16'h0000);
        wr(2, 1, 0, 3);
        wr(2, 1, 0, 0);
        do_commit();
        check("lit_inc2_ch2", chan(2), 16'h0002);
        wr(2, 2, 0, 3);
        do_commit();
        check("lit_clear_ch2", chan(2), 16'h0000);

        // Simultaneous commit, write and read
        wr(3, 0, 16'h1111, 3);
        do_commit();
        wr(3, 0, 16'hAAAA, 3);
        cyc(1, 1, 0, 3, 16'h5555, 3, 1, 1, 3);
        check("lit_sim_ch3", chan(3), 16'hAAAA);
        check("lit_sim_pending", int'(pending), 1);
        check("lit_sim_read", int'(rd_data), 16'h1111);
        do_commit();
        check("lit_sim_next_ch3", chan(3), 16'h5555);

        // Reset mid-operation
        for (int k = 0; k < N; k++) wr(k, 0, 16'h7000 + k, 3);
        cyc(0, 0, 3, 0, 0, 0, 1, 1, 2);
        check("lit_rst_flat", int'(dataOut == '0), 1);
        check("lit_rst_rd_valid", int'(rd_valid), 0);
        check("lit_rst_pending", int'(pending), 0);
        do_commit();
        check("lit_rst_discard", int'(dataOut == '0), 1);
        idle(2);

        chk_en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
